// File: rtl/npn4_pkg.sv
// Shared types and sizes for the 4-input NPN truth-table sweeper.
package npn4_pkg;
  localparam int unsigned N_IN = 4;
  localparam int unsigned TT_W = 16;

  typedef logic [TT_W-1:0] tt_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;
endpackage

// File: rtl/npn4_tt_compare.sv
// Combinational comparison of a captured truth table against its reference.
module npn4_tt_compare
  import npn4_pkg::*;
(
  input  logic [15:0] tt,
  input  logic [15:0] expected,
  output logic        match,
  output logic [4:0]  err_cnt,
  output logic [3:0]  mismatch_idx
);
  tt_t w_diff;

  assign w_diff = tt ^ expected;

  always_comb begin
    match        = (w_diff == '0);
    err_cnt      = '0;
    mismatch_idx = '0;
    for (int unsigned i = 0; i < TT_W; i++) begin
      if (w_diff[i]) err_cnt = err_cnt + 5'd1;
    end
    // Scan high to low so the lowest differing index is the last one written.
    for (int unsigned i = TT_W; i > 0; i--) begin
      if (w_diff[i-1]) mismatch_idx = 4'(i - 1);
    end
  end
endmodule

// File: rtl/npn4_tt_sweeper.sv
// Drives all 16 minterms into a 4-input function block, captures y and
// compares the resulting truth table against a latched reference.
module npn4_tt_sweeper
  import npn4_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] expected_tt,
  output logic [3:0]  x,
  input  logic        y,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt,
  output logic        match,
  output logic [4:0]  err_cnt,
  output logic [3:0]  mismatch_idx
);
  localparam logic [3:0] SETTLE_C = SETTLE[3:0];

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_m;
  logic [3:0] r_s;
  tt_t        r_exp;
  tt_t        r_tt;
  tt_t        w_tt_cap;
  logic       r_match;
  logic [4:0] r_err_cnt;
  logic [3:0] r_mismatch_idx;
  logic       w_accept;
  logic       w_sample;
  logic       w_last;
  logic       w_cmp_match;
  logic [4:0] w_cmp_err;
  logic [3:0] w_cmp_idx;

  assign w_accept = start && (r_state != RUN);
  assign w_sample = (r_state == RUN) && !abort && (r_s == SETTLE_C);
  assign w_last   = w_sample && (r_m == 4'd15);

  // Compare against the table including the bit captured on this edge.
  always_comb begin
    w_tt_cap      = r_tt;
    w_tt_cap[r_m] = y;
  end

  npn4_tt_compare u_cmp (
    .tt           (w_tt_cap),
    .expected     (r_exp),
    .match        (w_cmp_match),
    .err_cnt      (w_cmp_err),
    .mismatch_idx (w_cmp_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN: begin
        if (abort)       w_next = IDLE;
        else if (w_last) w_next = DONE;
      end
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m            <= '0;
      r_s            <= '0;
      r_exp          <= '0;
      r_tt           <= '0;
      r_match        <= 1'b0;
      r_err_cnt      <= '0;
      r_mismatch_idx <= '0;
    end else if (w_accept) begin
      r_exp          <= expected_tt;
      r_tt           <= '0;
      r_match        <= 1'b0;
      r_err_cnt      <= '0;
      r_mismatch_idx <= '0;
      r_m            <= '0;
      r_s            <= '0;
    end else if (r_state == RUN) begin
      if (abort) begin
        r_m            <= '0;
        r_s            <= '0;
        r_match        <= 1'b0;
        r_err_cnt      <= '0;
        r_mismatch_idx <= '0;
      end else if (w_sample) begin
        r_tt <= w_tt_cap;
        r_s  <= '0;
        if (w_last) begin
          r_m            <= '0;
          r_match        <= w_cmp_match;
          r_err_cnt      <= w_cmp_err;
          r_mismatch_idx <= w_cmp_idx;
        end else begin
          r_m <= r_m + 4'd1;
        end
      end else begin
        r_s <= r_s + 4'd1;
      end
    end
  end

  assign x            = r_m;
  assign busy         = (r_state == RUN);
  assign done         = (r_state == DONE);
  assign tt           = r_tt;
  assign match        = r_match;
  assign err_cnt      = r_err_cnt;
  assign mismatch_idx = r_mismatch_idx;
endmodule

// File: tb/tb_npn4_tt_sweeper.sv
// Self-checking bench: two sweepers (SETTLE 0 and 3) each driving a
// truth-table-defined function block, checked against a reference model.
module tb_npn4_tt_sweeper;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        st   [2];
  logic        ab   [2];
  logic [15:0] ex   [2];
  logic [15:0] fn   [2];
  logic [3:0]  xo   [2];
  logic        yv   [2];
  logic        bsy  [2];
  logic        dn   [2];
  logic [15:0] tto  [2];
  logic        mt   [2];
  logic [4:0]  ec   [2];
  logic [3:0]  mi   [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign yv[0] = fn[0][xo[0]];
  assign yv[1] = fn[1][xo[1]];

  npn4_tt_sweeper #(.SETTLE(0)) d0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .abort(ab[0]),
    .expected_tt(ex[0]), .x(xo[0]), .y(yv[0]), .busy(bsy[0]), .done(dn[0]),
    .tt(tto[0]), .match(mt[0]), .err_cnt(ec[0]), .mismatch_idx(mi[0])
  );

  npn4_tt_sweeper #(.SETTLE(3)) d1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .abort(ab[1]),
    .expected_tt(ex[1]), .x(xo[1]), .y(yv[1]), .busy(bsy[1]), .done(dn[1]),
    .tt(tto[1]), .match(mt[1]), .err_cnt(ec[1]), .mismatch_idx(mi[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int per_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic int lowest_diff(input logic [15:0] a, input logic [15:0] b);
    for (int i = 0; i < 16; i++) if (a[i] != b[i]) return i;
    return 0;
  endfunction

  task automatic chk_reset(input int d);
    chk($sformatf("rst_x%0d", d), 32'(xo[d]), 0);
    chk($sformatf("rst_busy%0d", d), 32'(bsy[d]), 0);
    chk($sformatf("rst_done%0d", d), 32'(dn[d]), 0);
    chk($sformatf("rst_tt%0d", d), 32'(tto[d]), 0);
    chk($sformatf("rst_match%0d", d), 32'(mt[d]), 0);
    chk($sformatf("rst_err%0d", d), 32'(ec[d]), 0);
    chk($sformatf("rst_idx%0d", d), 32'(mi[d]), 0);
  endtask

  // Called at a negedge; starts a sweep there and returns at the done negedge.
  task automatic sweep(input int d, input logic [15:0] f, input logic [15:0] e,
                       input int poke, input logic ab_with_start);
    int per  = per_of(d);
    int last = 16 * per;
    fn[d] = f; ex[d] = e; st[d] = 1'b1; ab[d] = ab_with_start;
    @(negedge clk);
    st[d] = 1'b0; ab[d] = 1'b0;
    chk("clr_tt", 32'(tto[d]), 0);
    chk("clr_match", 32'(mt[d]), 0);
    chk("clr_err", 32'(ec[d]), 0);
    chk("clr_idx", 32'(mi[d]), 0);
    for (int k = 0; k < last; k++) begin
      if (k > 0) @(negedge clk);
      st[d] = (k == poke);
      chk($sformatf("run_x_k%0d", k), 32'(xo[d]), 32'(k / per));
      chk("run_busy", 32'(bsy[d]), 1);
      chk("run_done", 32'(dn[d]), 0);
    end
    @(negedge clk);
    st[d] = 1'b0;
    chk("done_pulse", 32'(dn[d]), 1);
    chk("done_busy", 32'(bsy[d]), 0);
    chk("done_tt", 32'(tto[d]), 32'(f));
    chk("done_match", 32'(mt[d]), 32'(f == e));
    chk("done_err", 32'(ec[d]), 32'($countones(f ^ e)));
    chk("done_idx", 32'(mi[d]), 32'(lowest_diff(f, e)));
  endtask

  task automatic abort_run(input int d, input logic [15:0] f, input int k);
    int per = per_of(d);
    logic [15:0] mask = 16'((32'h1 << (k + 1)) - 1);
    fn[d] = f; ex[d] = $urandom; st[d] = 1'b1;
    @(negedge clk);
    st[d] = 1'b0;
    repeat ((k + 1) * per) @(negedge clk);
    ab[d] = 1'b1;
    @(negedge clk);
    ab[d] = 1'b0;
    chk("abt_busy", 32'(bsy[d]), 0);
    chk("abt_done", 32'(dn[d]), 0);
    chk("abt_x", 32'(xo[d]), 0);
    chk("abt_tt", 32'(tto[d]), 32'(f & mask));
    chk("abt_match", 32'(mt[d]), 0);
    chk("abt_err", 32'(ec[d]), 0);
    chk("abt_idx", 32'(mi[d]), 0);
    repeat (20) begin
      @(negedge clk);
      chk("abt_nodone", 32'(dn[d]), 0);
    end
  endtask

  initial begin
    logic [15:0] f, e;
    int d;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      st[i] = 1'b0; ab[i] = 1'b0; ex[i] = '0; fn[i] = '0;
    end
    repeat (2) @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    rst_n = 1'b1;
    @(negedge clk);

    // y = x0 & x1, SETTLE 0
    sweep(0, 16'h8888, 16'h8888, -1, 1'b0);
    @(negedge clk);
    chk("idle_done", 32'(dn[0]), 0);
    chk("hold_tt", 32'(tto[0]), 32'h8888);
    chk("hold_match", 32'(mt[0]), 1);
    ab[0] = 1'b1;
    @(negedge clk);
    ab[0] = 1'b0;
    chk("idle_abort_busy", 32'(bsy[0]), 0);
    chk("idle_abort_tt", 32'(tto[0]), 32'h8888);
    chk("idle_abort_match", 32'(mt[0]), 1);

    // parity, SETTLE 3
    sweep(1, 16'h6996, 16'h6996, -1, 1'b0);
    @(negedge clk);
    sweep(0, 16'h8888, 16'h0000, -1, 1'b0);
    @(negedge clk);
    // y = x3, then restart in the done cycle
    sweep(0, 16'hFF00, 16'hFF01, -1, 1'b0);
    f = 16'($urandom); e = 16'($urandom);
    sweep(0, f, e, -1, 1'b0);
    @(negedge clk);

    abort_run(1, 16'hFFFF, 5);
    sweep(1, 16'hA5C3, 16'hA5C3, -1, 1'b1);
    @(negedge clk);
    sweep(1, 16'h1234, 16'h1334, 7, 1'b0);
    @(negedge clk);
    chk("poke_idle_busy", 32'(bsy[1]), 0);

    for (int it = 0; it < 8; it++) begin
      d = int'($urandom_range(0, 1));
      f = 16'($urandom);
      case ($urandom_range(0, 2))
        0:       e = f;
        1:       e = f ^ 16'(32'h1 << $urandom_range(0, 15));
        default: e = 16'($urandom);
      endcase
      sweep(d, f, e, int'($urandom_range(0, 70)), 1'(($urandom_range(0, 3)) == 0));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      else begin
        @(negedge clk);
        @(negedge clk);
      end
    end
    for (int it = 0; it < 3; it++) begin
      abort_run(int'($urandom_range(0, 1)), 16'($urandom), int'($urandom_range(0, 14)));
    end

    // reset mid-sweep
    fn[1] = 16'hFFFF; ex[1] = 16'hFFFF; st[1] = 1'b1;
    @(negedge clk);
    st[1] = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset(0);
    chk_reset(1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (80) begin
      @(negedge clk);
      chk("post_rst_done", 32'(dn[1]), 0);
    end
    chk("post_rst_busy", 32'(bsy[1]), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
